pktunit_axis_pktfifo: RTL and testbench

PKTUNIT_AXIS_PKTFIFO -- requirements
Module: pktunit_axis_pktfifo

---
 rtl/pktunit_pkg.sv | 25 ++
 rtl/pktunit_sdp_ram.sv | 36 +++
 rtl/pktunit_axis_pktfifo.sv | 179 +++++++++++++++++
 tb/tb_pktunit_axis_pktfifo.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pktunit_pkg.sv
// Shared types and constants for the packet FIFO slice.
package pktunit_pkg;

  localparam int PKT_DATA_BYTES = 8;
  localparam int PKT_FLAGS_W    = 8;

  // One beat of a packet at the default data width.
  typedef struct packed {
    logic [PKT_DATA_BYTES*8-1:0] data;
    logic [PKT_FLAGS_W-1:0]      flags;
    logic [PKT_DATA_BYTES-1:0]   eop;
  } beat_t;

  // ACCEPT stores beats; DROP swallows the rest of an oversize packet.
  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } pkt_state_e;

  // Stored beat width: data bytes, one eop bit per byte, plus the flags byte.
  function automatic int beat_width(input int data_bytes);
    return data_bytes * 9 + PKT_FLAGS_W;
  endfunction

endpackage

// File: rtl/pktunit_sdp_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data,
// which lets a single-beat packet reach the output one cycle after it arrives.
module pktunit_sdp_ram #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read, holding its value whenever no read is requested.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pktunit_axis_pktfifo.sv
// Store-and-forward packet FIFO with three joined upstream channels
// (data/flags/eop) and three joined downstream channels. Packets larger than
// the whole store are discarded and counted.
module pktunit_axis_pktfifo
  import pktunit_pkg::*;
#(
  parameter int DATA_BYTES = PKT_DATA_BYTES,
  parameter int DEPTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_BYTES*8-1:0]   in_data_d,
  input  logic                      in_data_v,
  output logic                      in_data_r,
  input  logic [7:0]                in_flags_d,
  input  logic                      in_flags_v,
  output logic                      in_flags_r,
  input  logic [DATA_BYTES-1:0]     in_eop_d,
  input  logic                      in_eop_v,
  output logic                      in_eop_r,
  output logic [DATA_BYTES*8-1:0]   out_data_d,
  output logic                      out_data_v,
  input  logic                      out_data_r,
  output logic [7:0]                out_flags_d,
  output logic                      out_flags_v,
  input  logic                      out_flags_r,
  output logic [DATA_BYTES-1:0]     out_eop_d,
  output logic                      out_eop_v,
  input  logic                      out_eop_r,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic [31:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = beat_width(DATA_BYTES);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  pkt_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_start_q, wr_start_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d, pkt_cnt_q, pkt_cnt_d, pend_q, pend_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic          out_v_q, out_v_d;
  logic          init_q;

  logic          in_all_v, in_last, accept_ok, in_rdy, wr_en, wr_last;
  logic          full_stuck, drop_evt;
  logic          out_rdy, retire, retire_last, load, fetch;
  logic [CW-1:0] avail;
  logic [BW-1:0] wr_beat, rd_beat;

  // A beat moves only when all three channels present it together; inputs
  // stay closed during reset and for the first cycle after it.
  assign in_all_v   = in_data_v & in_flags_v & in_eop_v;
  assign in_last    = |in_eop_d;
  assign in_rdy     = in_all_v & accept_ok & ~rst & ~init_q;
  assign in_data_r  = in_rdy;
  assign in_flags_r = in_rdy;
  assign in_eop_r   = in_rdy;
  assign wr_en      = in_rdy & (state_q == ACCEPT);
  assign wr_last    = wr_en & in_last;
  assign wr_beat    = {in_data_d, in_flags_d, in_eop_d};

  // Store full of one unfinished packet: it can never complete.
  assign full_stuck = (level_q == FULL) && (pkt_cnt_q == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCEPT;
    else     state_q <= state_d;
  end

  // FSM next state: drop on a stuck store, resume after the dropped packet ends.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCEPT: if (full_stuck)        state_d = DROP;
      DROP:   if (in_rdy && in_last) state_d = ACCEPT;
    endcase
  end

  // FSM outputs: admission rule and the drop event.
  always_comb begin
    accept_ok = 1'b0;
    drop_evt  = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        accept_ok = (level_q < FULL);
        drop_evt  = full_stuck;
      end
      DROP:   accept_ok = 1'b1;
    endcase
  end

  // Output side: the RAM read register is the output data register. A new
  // beat is fetched whenever the slot is free or being emptied, from the
  // committed beats or from a packet whose last beat lands this cycle.
  assign out_rdy     = out_data_r & out_flags_r & out_eop_r;
  assign retire      = out_v_q & out_rdy;
  assign retire_last = retire & (|rd_beat[DATA_BYTES-1:0]);
  assign load        = ~out_v_q | out_rdy;
  assign avail       = level_q - pend_q - {{(CW-1){1'b0}}, out_v_q};
  assign fetch       = load & ((avail != '0) | wr_last);
  assign out_v_d     = load ? fetch : out_v_q;
  assign rd_ptr_d    = rd_ptr_q + AW'(fetch);

  // Pointer and counter bookkeeping for writes, commits, drops and retires.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_start_d = wr_start_q;
    pend_d     = pend_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (wr_last) begin
      wr_start_d = wr_ptr_q + AW'(1);
      pend_d     = '0;
    end else if (wr_en) begin
      pend_d = pend_q + CW'(1);
    end
    if (drop_evt) begin
      wr_ptr_d = wr_start_q;
      pend_d   = '0;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
    end
    level_d   = level_q + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, retire}
                - (drop_evt ? pend_q : '0);
    pkt_cnt_d = pkt_cnt_q + {{(CW-1){1'b0}}, wr_last} - {{(CW-1){1'b0}}, retire_last};
  end

  // Datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      wr_start_q <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
      out_v_q    <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_start_q <= wr_start_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      out_v_q    <= out_v_d;
      init_q     <= 1'b0;
    end
  end

  pktunit_sdp_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_beat),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_beat)
  );

  assign out_data_d  = rd_beat[BW-1 -: DATA_BYTES*8];
  assign out_flags_d = rd_beat[DATA_BYTES +: 8];
  assign out_eop_d   = rd_beat[DATA_BYTES-1:0];
  assign out_data_v  = out_v_q & ~rst;
  assign out_flags_v = out_v_q & ~rst;
  assign out_eop_v   = out_v_q & ~rst;
  assign level       = level_q;
  assign pkt_count   = pkt_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_pktunit_axis_pktfifo.sv
// Scoreboard bench for the packet FIFO: stimulus pushes expected beats of
// every packet that fits the store; a monitor pops on each output handshake.
`timescale 1ns/1ps
module tb_pktunit_axis_pktfifo;
  import pktunit_pkg::*;

  localparam int DB    = PKT_DATA_BYTES;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DB*8-1:0] in_data_d, out_data_d;
  logic [7:0]    in_flags_d, out_flags_d;
  logic [DB-1:0] in_eop_d, out_eop_d;
  logic          in_data_v, in_flags_v, in_eop_v, in_data_r, in_flags_r, in_eop_r;
  logic          out_data_v, out_flags_v, out_eop_v, out_data_r, out_flags_r, out_eop_r;
  logic [CW-1:0] level, pkt_count;
  logic [31:0]   drop_cnt;

  pktunit_axis_pktfifo #(.DATA_BYTES(DB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data_d(in_data_d), .in_data_v(in_data_v), .in_data_r(in_data_r),
    .in_flags_d(in_flags_d), .in_flags_v(in_flags_v), .in_flags_r(in_flags_r),
    .in_eop_d(in_eop_d), .in_eop_v(in_eop_v), .in_eop_r(in_eop_r),
    .out_data_d(out_data_d), .out_data_v(out_data_v), .out_data_r(out_data_r),
    .out_flags_d(out_flags_d), .out_flags_v(out_flags_v), .out_flags_r(out_flags_r),
    .out_eop_d(out_eop_d), .out_eop_v(out_eop_v), .out_eop_r(out_eop_r),
    .level(level), .pkt_count(pkt_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  int    ret_cnt = 0;
  int    rdy_mode = 0;   // 0 high, 1 low, 2 toggle, 3 random per channel
  int    pk_peak = 0;
  int    model_drops = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    if (mode == 0) {out_data_r, out_flags_r, out_eop_r} = 3'b111;
    if (mode == 1) {out_data_r, out_flags_r, out_eop_r} = 3'b000;
  endtask

  // Downstream ready pattern generator.
  initial begin
    {out_data_r, out_flags_r, out_eop_r} = 3'b111;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: {out_data_r, out_flags_r, out_eop_r} = 3'b111;
        1: {out_data_r, out_flags_r, out_eop_r} = 3'b000;
        2: {out_data_r, out_flags_r, out_eop_r} = {3{~out_data_r}};
        default: begin
          out_data_r  = ($urandom_range(0, 3) != 0);
          out_flags_r = ($urandom_range(0, 3) != 0);
          out_eop_r   = ($urandom_range(0, 3) != 0);
        end
      endcase
    end
  end

  // Monitor: checks each output handshake against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_data_v && out_data_r && out_flags_r && out_eop_r) begin
        chk("out_v_join", {62'd0, out_flags_v, out_eop_v}, 64'd3);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got data %0h required no beat", out_data_d);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data_d, e.data);
          chk("out_flags", {56'd0, out_flags_d}, {56'd0, e.flags});
          chk("out_eop", {56'd0, out_eop_d}, {56'd0, e.eop});
        end
        ret_cnt++;
      end
      if ((in_data_v || in_flags_v || in_eop_v) && !(in_data_v && in_flags_v && in_eop_v))
        chk("in_r_join", {61'd0, in_data_r, in_flags_r, in_eop_r}, 64'd0);
      if (int'(pkt_count) > pk_peak) pk_peak = int'(pkt_count);
    end
  end

  function automatic beat_t mk_beat(input logic [DB-1:0] eop);
    beat_t b;
    b.data  = {$urandom, $urandom};
    b.flags = 8'($urandom);
    b.eop   = eop;
    return b;
  endfunction

  // Present one beat from a negedge; flags valid may trail by 'lag' cycles.
  task automatic send_beat(input beat_t b, input int lag);
    int guard = 0;
    int l = lag;
    bit hs = 0;
    in_data_d = b.data; in_flags_d = b.flags; in_eop_d = b.eop;
    in_data_v = 1'b1; in_eop_v = 1'b1; in_flags_v = (l == 0);
    while (!hs) begin
      #1;
      hs = in_data_v && in_flags_v && in_eop_v && in_data_r && in_flags_r && in_eop_r;
      @(negedge clk);
      if (!hs) begin
        if (l > 0) l--;
        in_flags_v = (l == 0);
        guard++;
        if (guard > 3000) begin
          n_checks++;
          n_errors++;
          $display("FAIL in_timeout: beat not accepted after %0d cycles, required acceptance", guard);
          hs = 1;
        end
      end
    end
    in_data_v = 1'b0; in_flags_v = 1'b0; in_eop_v = 1'b0;
  endtask

  // lag_mode: 0 no lag, 1 flags one cycle late, 2 random lag and bubbles.
  task automatic send_pkt(input int len, input int lag_mode, input logic [DB-1:0] last_eop);
    beat_t pkt[$];
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) pkt.push_back(mk_beat(last_eop != 0 ? last_eop : DB'($urandom_range(1, 255))));
      else              pkt.push_back(mk_beat('0));
    end
    if (len <= DEPTH) foreach (pkt[i]) exp_q.push_back(pkt[i]);
    else model_drops++;
    foreach (pkt[i]) begin
      send_beat(pkt[i], (lag_mode == 2) ? $urandom_range(0, 1) : lag_mode);
      if (lag_mode == 2 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int limit);
    int guard = 0;
    while (exp_q.size() != 0 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    beat_t b0, b1, b2;
    int base, guard;
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b0, b1, b2;
    int base, guard;
    rst = 1'b1;
    in_data_d = '0; in_flags_d = '0; in_eop_d = '0;
    in_data_v = 1'b1; in_flags_v = 1'b1; in_eop_v = 1'b1;
    set_rdy(0);

    // Reset state and closed inputs during/after reset.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_r", {61'd0, in_data_r, in_flags_r, in_eop_r}, 64'd0);
    chk("rst_out_v", {61'd0, out_data_v, out_flags_v, out_eop_v}, 64'd0);
    chk("rst_level", level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_r", {61'd0, in_data_r, in_flags_r, in_eop_r}, 64'd0);
    in_data_v = 1'b0; in_flags_v = 1'b0; in_eop_v = 1'b0;
    @(negedge clk);

    // 3-beat packet, output valid exactly the cycle after the last accept.
    b0 = mk_beat(8'h00); b1 = mk_beat(8'h00); b2 = mk_beat(8'h0F);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    send_beat(b0, 0);
    send_beat(b1, 0);
    #1 chk("lat_not_early", out_data_v, 0);
    send_beat(b2, 0);
    #1 chk("lat_valid", out_data_v, 1);
    wait_drain(50);
    chk("lat_level", level, 0);
    chk("lat_pkt_count", pkt_count, 0);

    // Flags channel one cycle late on every beat.
    @(negedge clk);
    base = ret_cnt;
    send_pkt(4, 1, 0);
    wait_drain(100);
    chk("lag_beats", ret_cnt - base, 4);

    // 1,5,2 beat packets stored, then drained with ready toggling.
    @(negedge clk);
    set_rdy(1);
    pk_peak = 0;
    send_pkt(1, 0, 0); send_pkt(5, 0, 0); send_pkt(2, 0, 0);
    #1 chk("three_pkt_count", pkt_count, 3);
    @(negedge clk);
    set_rdy(2);
    wait_drain(100);
    chk("three_pkt_peak", pk_peak, 3);
    chk("three_pkt_level", level, 0);

    // Back-to-back packets stream with no idle output cycle.
    @(negedge clk);
    set_rdy(1);
    send_pkt(3, 0, 0); send_pkt(2, 0, 0);
    set_rdy(0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stream_v", out_data_v, 1);
      @(negedge clk);
    end
    #1 chk("stream_end_v", out_data_v, 0);
    wait_drain(50);

    // Fill to 63 with downstream stalled, one more beat fits, then closed.
    @(negedge clk);
    set_rdy(1);
    send_pkt(63, 0, 0);
    #1;
    chk("fill_level63", level, 63);
    chk("fill_pkt_count", pkt_count, 1);
    b0 = mk_beat(8'h00); b1 = mk_beat(8'h81);
    exp_q.push_back(b0); exp_q.push_back(b1);
    in_data_d = b0.data; in_flags_d = b0.flags; in_eop_d = b0.eop;
    in_data_v = 1'b1; in_flags_v = 1'b1; in_eop_v = 1'b1;
    #1 chk("fill_r_at63", {61'd0, in_data_r, in_flags_r, in_eop_r}, 64'd7);
    @(negedge clk);
    in_data_d = b1.data; in_flags_d = b1.flags; in_eop_d = b1.eop;
    #1;
    chk("fill_level64", level, 64);
    chk("fill_r_at64", {61'd0, in_data_r, in_flags_r, in_eop_r}, 64'd0);
    @(negedge clk);
    set_rdy(0);
    send_beat(b1, 0);
    wait_drain(300);
    chk("fill_drain_level", level, 0);

    // Oversize packet dropped, following packet intact.
    @(negedge clk);
    send_pkt(70, 0, 0);
    send_pkt(2, 0, 0);
    wait_drain(300);
    chk("drop_cnt_one", drop_cnt, 1);
    chk("drop_level", level, 0);

    // Reset in the middle of outputting a 4-beat packet.
    @(negedge clk);
    set_rdy(1);
    send_pkt(4, 0, 0);
    base = ret_cnt;
    set_rdy(0);
    guard = 0;
    while (ret_cnt < base + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_rst_progress", ret_cnt - base, 2);
    rst = 1'b1;
    exp_q.delete();
    model_drops = 0;
    #1 chk("mid_rst_out_v", out_data_v, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_v_after", {61'd0, out_data_v, out_flags_v, out_eop_v}, 64'd0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    send_pkt(3, 0, 0);
    wait_drain(50);

    // Randomized traffic against the length-based drop rule.
    @(negedge clk);
    set_rdy(3);
    for (int p = 0; p < 40; p++) begin
      int r, len;
      r = $urandom_range(0, 19);
      if (r == 0)      len = $urandom_range(65, 70);
      else if (r == 1) len = $urandom_range(60, 64);
      else             len = $urandom_range(1, 12);
      send_pkt(len, 2, 0);
    end
    wait_drain(8000);
    chk("rand_drop_cnt", drop_cnt, model_drops);
    chk("rand_level", level, 0);
    chk("rand_pkt_count", pkt_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
